aes_job_arbiter: RTL and testbench

//  Shares one AES128 encrypt/decrypt core between two requesters (serial host = port 0, auxiliary DMA = port 1).

---
 rtl/aes_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 24 ++
 rtl/aes_job_arbiter.sv | 167 ++++++++++++++++
 tb/tb_aes_job_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES job arbiter: FSM state encoding,
// core mode values and the AES block width.
package aes_pkg;

  localparam int AES_W = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    KEY,
    KEYWAIT,
    RUN,
    RUNWAIT,
    RESP,
    ABORT
  } arbStateT;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. On a tie the port that did not win last time
// is chosen; the owner reports the actual winner through upd/updIdx.
module rr_arbiter2 (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       updIdx,
  output logic [1:0] gnt
);

  logic rrPtr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = rrPtr ? 2'b01 : 2'b10;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) rrPtr <= 1'b0;
    else if (upd) rrPtr <= updIdx;
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one AES128 core between the host (port 0) and the DMA (port 1):
// arbitrates, latches the job, sequences key load / start and reports status.
//
// state   | meaning
// IDLE    | waiting for a request
// LATCH   | grant cycle, job inputs captured
// KEY     | key expansion pulse
// KEYWAIT | waiting for expanded key
// RUN     | block start pulse
// RUNWAIT | waiting for core result
// RESP    | Done with Err=0
// ABORT   | core reset, Done with Err=1
module aes_job_arbiter
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CW          = 13
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       Req,
  input  logic [1:0]       Mode,
  input  logic [AES_W-1:0] Text0,
  input  logic [AES_W-1:0] Text1,
  input  logic [AES_W-1:0] Key0,
  input  logic [AES_W-1:0] Key1,
  output logic [1:0]       Grant,
  output logic [1:0]       Done,
  output logic             Err,
  output logic [AES_W-1:0] ResultOut,
  output logic             CoreSel,
  output logic [AES_W-1:0] CoreText,
  output logic [AES_W-1:0] CoreKey,
  output logic             CoreKeyLoad,
  input  logic             CoreKeyRy,
  output logic             CoreStart,
  input  logic             CoreRy,
  input  logic [AES_W-1:0] CoreResult,
  output logic             CoreAbort
);

  // The abort decision looks at the count before its increment, so the
  // abort state lands exactly TIMEOUT_CYC cycles after the start pulse.
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC - 2);

  arbStateT         state, stateNext;
  logic [1:0]       arbGnt;
  logic             winner;
  logic [1:0]       winnerOh;
  logic             keyValid;
  logic [AES_W-1:0] lastKey;
  logic [AES_W-1:0] selKey;
  logic [CW-1:0]    toCnt;
  logic             keyHit, toHit;
  logic [1:0]       grantNext, doneNext;
  logic             errNext, keyLoadNext, startNext, abortNext;

  rr_arbiter2 uArb (
    .Clk    (Clk),
    .Rst    (Rst),
    .req    (Req),
    .upd    (state == LATCH),
    .updIdx (winner),
    .gnt    (arbGnt)
  );

  assign winnerOh = winner ? 2'b10 : 2'b01;
  assign selKey   = winner ? Key1 : Key0;
  assign keyHit   = keyValid && (selKey == lastKey);
  assign toHit    = (toCnt == TO_LIM);

  always_comb begin
    stateNext   = state;
    grantNext   = '0;
    doneNext    = '0;
    errNext     = 1'b0;
    keyLoadNext = 1'b0;
    startNext   = 1'b0;
    abortNext   = 1'b0;
    case (state)
      IDLE: if (|Req) begin
        stateNext = LATCH;
        grantNext = arbGnt;
      end
      LATCH: if (keyHit) begin
        stateNext = RUN;
        startNext = 1'b1;
      end else begin
        stateNext   = KEY;
        keyLoadNext = 1'b1;
      end
      KEY: stateNext = KEYWAIT;
      KEYWAIT: if (CoreKeyRy) begin
        stateNext = RUN;
        startNext = 1'b1;
      end else if (toHit) begin
        stateNext = ABORT;
        abortNext = 1'b1;
        doneNext  = winnerOh;
        errNext   = 1'b1;
      end
      RUN: stateNext = RUNWAIT;
      RUNWAIT: if (CoreRy) begin
        stateNext = RESP;
        doneNext  = winnerOh;
      end else if (toHit) begin
        stateNext = ABORT;
        abortNext = 1'b1;
        doneNext  = winnerOh;
        errNext   = 1'b1;
      end
      RESP:    stateNext = IDLE;
      ABORT:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      Grant       <= '0;
      Done        <= '0;
      Err         <= 1'b0;
      CoreKeyLoad <= 1'b0;
      CoreStart   <= 1'b0;
      CoreAbort   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      state       <= stateNext;
      Grant       <= grantNext;
      Done        <= doneNext;
      Err         <= errNext;
      CoreKeyLoad <= keyLoadNext;
      CoreStart   <= startNext;
      CoreAbort   <= abortNext;
      if (state == IDLE && |Req) winner <= arbGnt[1];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      CoreText  <= '0;
      CoreKey   <= '0;
      CoreSel   <= MODE_ENC;
      ResultOut <= '0;
      lastKey   <= '0;
      keyValid  <= 1'b0;
      toCnt     <= '0;
    end else begin
      if (state == LATCH) begin
        CoreText <= winner ? Text1 : Text0;
        CoreKey  <= selKey;
        CoreSel  <= Mode[winner] ? MODE_DEC : MODE_ENC;
      end
      if (state == KEY || state == RUN) toCnt <= '0;
      else if (state == KEYWAIT || state == RUNWAIT) toCnt <= toCnt + CW'(1);
      if (state == KEYWAIT && CoreKeyRy) begin
        lastKey  <= CoreKey;
        keyValid <= 1'b1;
      end
      // An aborted core may have lost its expanded key.
      if (state == ABORT) keyValid <= 1'b0;
      if (state == RUNWAIT && CoreRy) ResultOut <= CoreResult;
    end
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter with a behavioural stand-in for the AES core.
module tb_aes_job_arbiter;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_B    = 128'hfedcba9876543210f0e1d2c3b4a59687;
  localparam logic [127:0] T0     = 128'h11111111222222223333333344444444;
  localparam logic [127:0] T1     = 128'h5555555566666666777777778888aaaa;
  localparam logic [127:0] T2     = 128'hcafef00d0badbeef1234567890abcdef;
  localparam logic [127:0] SPUR   = 128'hdeaddeaddeaddeaddeaddeaddeaddead;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [1:0]   Req = '0;
  logic [1:0]   Mode = '0;
  logic [127:0] Text0 = '0, Text1 = '0, Key0 = '0, Key1 = '0;
  logic [1:0]   Grant, Done;
  logic         Err, CoreSel, CoreKeyLoad, CoreKeyRy, CoreStart, CoreRy, CoreAbort;
  logic [127:0] ResultOut, CoreText, CoreKey, CoreResult;

  int total = 0;
  int bad = 0;

  logic [7:0] coreCnt, keyCnt;
  logic       keyRyQ;
  logic       ryEnable = 1'b0;
  logic       spurRy = 1'b0;
  int         coreLat = 3;
  int         keyLoads = 0;

  aes_job_arbiter #(.TIMEOUT_CYC(16), .CW(13)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Mode(Mode),
    .Text0(Text0), .Text1(Text1), .Key0(Key0), .Key1(Key1),
    .Grant(Grant), .Done(Done), .Err(Err), .ResultOut(ResultOut),
    .CoreSel(CoreSel), .CoreText(CoreText), .CoreKey(CoreKey),
    .CoreKeyLoad(CoreKeyLoad), .CoreKeyRy(CoreKeyRy), .CoreStart(CoreStart),
    .CoreRy(CoreRy), .CoreResult(CoreResult), .CoreAbort(CoreAbort)
  );

  always #5 Clk = ~Clk;

  function automatic logic [127:0] coreModel(input logic sel, input logic [127:0] t, input logic [127:0] k);
    if (!sel && t == FIPS_P && k == FIPS_K) return FIPS_C;
    if (sel && t == FIPS_C && k == FIPS_K) return FIPS_P;
    return t ^ k ^ {128{sel}};
  endfunction

  // Core stand-in: key ready 3 cycles after load, result pulse coreLat cycles after start.
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      coreCnt <= '0;
      keyCnt  <= '0;
      keyRyQ  <= 1'b0;
    end else begin
      if (CoreAbort) coreCnt <= '0;
      else if (CoreStart) coreCnt <= 8'(coreLat);
      else if (coreCnt != 0) coreCnt <= coreCnt - 8'd1;
      if (CoreKeyLoad || CoreAbort) begin
        keyCnt <= 8'd3;
        keyRyQ <= 1'b0;
      end else if (keyCnt != 0) begin
        keyCnt <= keyCnt - 8'd1;
        if (keyCnt == 8'd1) keyRyQ <= 1'b1;
      end
    end
  end

  always @(posedge Clk) if (Rst && CoreKeyLoad) keyLoads <= keyLoads + 1;

  assign CoreKeyRy  = keyRyQ;
  assign CoreRy     = (ryEnable && coreCnt == 8'd1) || spurRy;
  assign CoreResult = spurRy ? SPUR : coreModel(CoreSel, CoreText, CoreKey);

  task automatic waitDone(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (Done != 2'b00) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitGrant(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (Grant != 2'b00) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitStart(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (CoreStart) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic ok;
    #1 Rst = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    ryEnable = 1'b0;
    Key0 = K_A; Text0 = T0; Mode = 2'b00;
    @(negedge Clk);
    Req = 2'b01;
    waitGrant(ok);
    Req = 2'b00;
    waitStart(ok);
    repeat (2) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    total++;
    if ({Grant, Done, Err, CoreSel, CoreKeyLoad, CoreStart, CoreAbort} !== 9'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {Grant, Done, Err, CoreSel, CoreKeyLoad, CoreStart, CoreAbort});
    end
    total++;
    if (CoreText !== '0 || CoreKey !== '0 || ResultOut !== '0) begin
      bad++; $display("FAIL reset_data: text=%h key=%h res=%h want 0", CoreText, CoreKey, ResultOut);
    end
    ryEnable = 1'b1;
    coreLat = 3;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Req = 2'b01;
    total++;
    if (Grant !== 2'b00) begin bad++; $display("FAIL grant_early: got %b want 00", Grant); end
    @(negedge Clk);
    total++;
    if (Grant !== 2'b01) begin bad++; $display("FAIL grant_cycle2: got %b want 01", Grant); end
    Req = 2'b00;
    waitDone(ok);
    total++;
    if (!ok || Done !== 2'b01 || Err !== 1'b0) begin
      bad++; $display("FAIL reset_job_done: got done=%b err=%b want 01/0", Done, Err);
    end
    total++;
    if (ResultOut !== (T0 ^ K_A)) begin bad++; $display("FAIL reset_job_res: got %h want %h", ResultOut, T0 ^ K_A); end
    @(negedge Clk);
  endtask

  task automatic test_fips_enc();
    logic ok;
    int loads0;
    loads0 = keyLoads;
    Key0 = FIPS_K; Text0 = FIPS_P; Mode = 2'b00;
    Req = 2'b01;
    waitGrant(ok);
    Req = 2'b00;
    total++;
    if (!ok || Grant !== 2'b01) begin bad++; $display("FAIL enc_grant: got %b want 01", Grant); end
    waitDone(ok);
    total++;
    if (!ok || Done !== 2'b01 || Err !== 1'b0) begin bad++; $display("FAIL enc_done: got done=%b err=%b want 01/0", Done, Err); end
    total++;
    if (ResultOut !== FIPS_C) begin bad++; $display("FAIL enc_result: got %h want %h", ResultOut, FIPS_C); end
    total++;
    if (keyLoads - loads0 != 1) begin bad++; $display("FAIL enc_keyload: got %0d want 1", keyLoads - loads0); end
    @(negedge Clk);
  endtask

  task automatic test_fips_dec();
    logic ok;
    int loads0;
    loads0 = keyLoads;
    Key0 = K_B; Text0 = T2;
    Key1 = FIPS_K; Text1 = FIPS_C; Mode = 2'b10;
    Req = 2'b10;
    waitGrant(ok);
    Req = 2'b00;
    total++;
    if (!ok || Grant !== 2'b10) begin bad++; $display("FAIL dec_grant: got %b want 10", Grant); end
    @(negedge Clk);
    Text1 = '0; Key1 = '0; Mode = 2'b00;
    waitDone(ok);
    total++;
    if (!ok || Done !== 2'b10 || Err !== 1'b0) begin bad++; $display("FAIL dec_done: got done=%b err=%b want 10/0", Done, Err); end
    total++;
    if (ResultOut !== FIPS_P) begin bad++; $display("FAIL dec_result: got %h want %h", ResultOut, FIPS_P); end
    total++;
    if (keyLoads != loads0) begin bad++; $display("FAIL dec_keyload: got %0d want 0", keyLoads - loads0); end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] expSeq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] prevGrant;
    logic ok;
    int n;
    n = 0;
    prevGrant = 2'b00;
    Key0 = K_A; Text0 = T0; Key1 = K_A; Text1 = T1; Mode = 2'b00;
    Req = 2'b11;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge Clk);
      if (Grant != 2'b00 && prevGrant != 2'b00) begin
        total++; bad++; $display("FAIL grant_consec: got %b then %b", prevGrant, Grant);
      end
      if (Grant != 2'b00) begin
        total++;
        if (Grant !== expSeq[n]) begin bad++; $display("FAIL rr_seq%0d: got %b want %b", n, Grant, expSeq[n]); end
        n++;
        if (n == 4) Req = 2'b00;
      end
      prevGrant = Grant;
    end
    Req = 2'b00;
    total++;
    if (n != 4) begin bad++; $display("FAIL rr_count: got %0d want 4", n); end
    waitDone(ok);
    total++;
    if (!ok || Done !== 2'b10 || ResultOut !== (T1 ^ K_A)) begin
      bad++; $display("FAIL rr_last: got done=%b res=%h want 10/%h", Done, ResultOut, T1 ^ K_A);
    end
    @(negedge Clk);
  endtask

  task automatic test_timeout();
    logic ok;
    ryEnable = 1'b0;
    Key0 = K_B; Text0 = T0;
    Req = 2'b01;
    waitGrant(ok);
    Req = 2'b00;
    waitStart(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL to_start: got none want CoreStart"); end
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      if (k == 15) begin
        total++;
        if (CoreAbort !== 1'b0 || Done !== 2'b00) begin bad++; $display("FAIL to_early: got abort=%b done=%b want 0/00", CoreAbort, Done); end
      end
    end
    total++;
    if (CoreAbort !== 1'b1 || Done !== 2'b01 || Err !== 1'b1) begin
      bad++; $display("FAIL to_abort: got abort=%b done=%b err=%b want 1/01/1", CoreAbort, Done, Err);
    end
    total++;
    if (ResultOut !== (T1 ^ K_A)) begin bad++; $display("FAIL to_result_hold: got %h want %h", ResultOut, T1 ^ K_A); end
    @(negedge Clk);
  endtask

  task automatic test_timeout_edge();
    logic ok;
    logic sawAbort;
    int loads0;
    loads0 = keyLoads;
    sawAbort = 1'b0;
    ryEnable = 1'b1;
    coreLat = 15;
    Key0 = K_B; Text0 = T2;
    Req = 2'b01;
    waitGrant(ok);
    Req = 2'b00;
    waitStart(ok);
    total++;
    if (keyLoads - loads0 != 1) begin bad++; $display("FAIL edge_keyreload: got %0d want 1", keyLoads - loads0); end
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      if (CoreAbort) sawAbort = 1'b1;
    end
    total++;
    if (Done !== 2'b01 || Err !== 1'b0 || sawAbort !== 1'b0) begin
      bad++; $display("FAIL edge_done: got done=%b err=%b abort=%b want 01/0/0", Done, Err, sawAbort);
    end
    total++;
    if (ResultOut !== (T2 ^ K_B)) begin bad++; $display("FAIL edge_result: got %h want %h", ResultOut, T2 ^ K_B); end
    coreLat = 3;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_spurious();
    spurRy = 1'b1;
    repeat (2) @(negedge Clk);
    spurRy = 1'b0;
    @(negedge Clk);
    total++;
    if (ResultOut !== (T2 ^ K_B) || Done !== 2'b00) begin
      bad++; $display("FAIL spurious_ry: got res=%h done=%b want %h/00", ResultOut, Done, T2 ^ K_B);
    end
  endtask

  initial begin
    test_reset();
    test_fips_enc();
    test_fips_dec();
    test_back_to_back();
    test_timeout();
    test_timeout_edge();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
